mem_bus_arbiter: RTL



---
 rtl/arb_pkg.sv | 14 +
 rtl/arb_port_buf.sv | 47 ++++
 rtl/mem_bus_arbiter.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/arb_pkg.sv
// Shared types and constants for mem_bus_arbiter: FSM state encoding, strobe width, default widths.
package arb_pkg;
  localparam int STRB_W     = 4;
  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;

  typedef enum logic [2:0] {
    IDLE,
    D_ADDR,
    D_DATA,
    I_ADDR,
    I_DATA
  } arb_state_t;
endpackage

// File: rtl/arb_port_buf.sv
// Per-port result buffer: done flag, hold register and stall equation.
// Optional feature macro: ARB_RDATA_BYPASS_EN (forward bus data in the data_ok cycle).
module arb_port_buf
  import arb_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              set,
  input  logic              clr,
  input  logic              cancel,
  input  logic [DATA_W-1:0] load_val,
  output logic [DATA_W-1:0] rdata,
  output logic              stall,
  output logic              done
);

  logic [DATA_W-1:0] hold;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      done <= 1'b0;
      hold <= '0;
    end else begin
      if (set) hold <= load_val;
`ifdef ARB_RDATA_BYPASS_EN
      // The result is consumed in the data_ok cycle itself, so an advance then wins.
      if (clr)      done <= 1'b0;
      else if (set) done <= 1'b1;
`else
      if (set)      done <= 1'b1;
      else if (clr) done <= 1'b0;
`endif
    end
  end

`ifdef ARB_RDATA_BYPASS_EN
  assign stall = (req & ~done & ~set) | cancel;
  assign rdata = set ? load_val : hold;
`else
  assign stall = (req & ~done) | cancel;
  assign rdata = hold;
`endif

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one memory bus between the fetch and data ports; data has priority, one transaction in flight.
// Optional feature macro: ARB_RDATA_BYPASS_EN (same-cycle result forwarding and chained transactions).
module mem_bus_arbiter
  import arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inst_req,
  input  logic [ADDR_W-1:0] inst_addr,
  output logic [DATA_W-1:0] inst_rdata,
  output logic              inst_stall,
  input  logic              data_req,
  input  logic [STRB_W-1:0] data_wen,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic [DATA_W-1:0] data_rdata,
  output logic              data_stall,
  input  logic              pipe_adv,
  input  logic              flush,
  output logic              bus_req,
  output logic              bus_wr,
  output logic [STRB_W-1:0] bus_wstrb,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_addr_ok,
  input  logic              bus_data_ok,
  input  logic [DATA_W-1:0] bus_rdata
);

  arb_state_t state;
  logic       cancel;
  logic       inst_done, data_done;
  logic       inst_pending, data_pending;
  logic       in_fetch, inst_set, data_set;

  assign inst_pending = inst_req & ~inst_done;
  assign data_pending = data_req & ~data_done;
  assign in_fetch     = (state == I_ADDR) || (state == I_DATA);
  assign data_set     = (state == D_DATA) & bus_data_ok;
  // A flush landing in the data_ok cycle still drops the fetched word.
  assign inst_set     = (state == I_DATA) & bus_data_ok & ~cancel & ~flush;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cancel    <= 1'b0;
      bus_req   <= 1'b0;
      bus_wr    <= 1'b0;
      bus_wstrb <= '0;
      bus_addr  <= '0;
      bus_wdata <= '0;
    end else begin
      if ((state == I_DATA) && bus_data_ok) cancel <= 1'b0;
      else if (in_fetch && flush)           cancel <= 1'b1;

      case (state)
        IDLE: begin
          if (data_pending) begin
            state     <= D_ADDR;
            bus_req   <= 1'b1;
            bus_wr    <= |data_wen;
            bus_wstrb <= data_wen;
            bus_addr  <= data_addr;
            bus_wdata <= data_wdata;
          end else if (inst_pending) begin
            state     <= I_ADDR;
            bus_req   <= 1'b1;
            bus_wr    <= 1'b0;
            bus_wstrb <= '0;
            bus_addr  <= inst_addr;
            bus_wdata <= '0;
          end
        end
        D_ADDR: if (bus_addr_ok) begin
          state   <= D_DATA;
          bus_req <= 1'b0;
        end
        I_ADDR: if (bus_addr_ok) begin
          state   <= I_DATA;
          bus_req <= 1'b0;
        end
        D_DATA: if (bus_data_ok) begin
          state <= IDLE;
`ifdef ARB_RDATA_BYPASS_EN
          if (inst_pending) begin
            state     <= I_ADDR;
            bus_req   <= 1'b1;
            bus_wr    <= 1'b0;
            bus_wstrb <= '0;
            bus_addr  <= inst_addr;
            bus_wdata <= '0;
          end
`endif
        end
        I_DATA: if (bus_data_ok) begin
          state <= IDLE;
`ifdef ARB_RDATA_BYPASS_EN
          if (data_pending) begin
            state     <= D_ADDR;
            bus_req   <= 1'b1;
            bus_wr    <= |data_wen;
            bus_wstrb <= data_wen;
            bus_addr  <= data_addr;
            bus_wdata <= data_wdata;
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

  arb_port_buf #(.DATA_W(DATA_W)) u_inst_buf (
    .clk      (clk),
    .rst      (rst),
    .req      (inst_req),
    .set      (inst_set),
    .clr      (pipe_adv | flush),
    .cancel   (cancel),
    .load_val (bus_rdata),
    .rdata    (inst_rdata),
    .stall    (inst_stall),
    .done     (inst_done)
  );

  // Writes return no data, so their hold value is zero.
  arb_port_buf #(.DATA_W(DATA_W)) u_data_buf (
    .clk      (clk),
    .rst      (rst),
    .req      (data_req),
    .set      (data_set),
    .clr      (pipe_adv),
    .cancel   (1'b0),
    .load_val (bus_wr ? '0 : bus_rdata),
    .rdata    (data_rdata),
    .stall    (data_stall),
    .done     (data_done)
  );

endmodule
